// File: rtl/pm_sorter_pkg.sv
// Shared types and bitonic-network geometry helpers for the path-metric sorter.
package pm_sorter_pkg;

  localparam int PM_WIDTH_DEF = 8;
  localparam int LOG_N_DEF    = 3;

  typedef struct packed {
    logic [PM_WIDTH_DEF-1:0] pm;
    logic [LOG_N_DEF-1:0]    idx;
  } elem_t;

  function automatic int stages(input int log_n);
    return log_n * (log_n + 1) / 2;
  endfunction

  // Layer number -> merge phase p (block size 2^p); phases 1..LOG_N own p layers each.
  function automatic int phase(input int stage);
    int s, p;
    s = stage;
    p = 1;
    for (int k = 0; k < 8; k++)
      if (s >= p) begin
        s -= p;
        p++;
      end
    return p;
  endfunction

  // Layer number -> compare distance exponent within its phase (p-1 down to 0).
  function automatic int span(input int stage);
    int s, p;
    s = stage;
    p = 1;
    for (int k = 0; k < 8; k++)
      if (s >= p) begin
        s -= p;
        p++;
      end
    return p - 1 - s;
  endfunction

  function automatic int partner(input int stage, input int i);
    return i ^ (1 << span(stage));
  endfunction

  // 1 = descending comparator; the final phase is always ascending.
  function automatic logic dir(input int stage, input int i);
    return 1'((i >> phase(stage)) & 1);
  endfunction

endpackage

// File: rtl/pm_sorter_pipe_cas_tag.sv
// Combinational compare-exchange on tagged path metrics.
// PM_SORTER_TIEBREAK_EN: compare on {pm, idx} for a stable ordering of equal metrics.
module cas_tag #(
  parameter int PM_WIDTH  = 8,
  parameter int IDX_WIDTH = 3
) (
  input  logic [PM_WIDTH-1:0]  a_pm,
  input  logic [IDX_WIDTH-1:0] a_idx,
  input  logic [PM_WIDTH-1:0]  b_pm,
  input  logic [IDX_WIDTH-1:0] b_idx,
  input  logic                 desc,
  output logic [PM_WIDTH-1:0]  lo_pm,
  output logic [IDX_WIDTH-1:0] lo_idx,
  output logic [PM_WIDTH-1:0]  hi_pm,
  output logic [IDX_WIDTH-1:0] hi_idx
);

`ifdef PM_SORTER_TIEBREAK_EN
  localparam int KW = PM_WIDTH + IDX_WIDTH;
  logic [KW-1:0] ka, kb;
  assign ka = {a_pm, a_idx};
  assign kb = {b_pm, b_idx};
`else
  localparam int KW = PM_WIDTH;
  logic [KW-1:0] ka, kb;
  assign ka = a_pm;
  assign kb = b_pm;
`endif

  logic swap;
  assign swap = desc ? (ka < kb) : (kb < ka);

  assign lo_pm  = swap ? b_pm  : a_pm;
  assign lo_idx = swap ? b_idx : a_idx;
  assign hi_pm  = swap ? a_pm  : b_pm;
  assign hi_idx = swap ? a_idx : b_idx;

endmodule

// File: rtl/pm_sorter_pipe.sv
// Registered bitonic sorter for SCL path metrics; one network layer per pipeline stage.
// Optional PM_SORTER_TIEBREAK_EN (in cas_tag) makes equal-metric ordering stable.
module pm_sorter_pipe
  import pm_sorter_pkg::*;
#(
  parameter  int PM_WIDTH  = PM_WIDTH_DEF,
  parameter  int LOG_N     = LOG_N_DEF,
  localparam int N         = 1 << LOG_N,
  localparam int IDX_WIDTH = LOG_N,
  localparam int STAGES    = stages(LOG_N)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      Flush,
  input  logic                      In_valid,
  output logic                      In_ready,
  input  logic [N*PM_WIDTH-1:0]     In_pm,
  output logic                      Out_valid,
  input  logic                      Out_ready,
  output logic [N*PM_WIDTH-1:0]     Out_pm,
  output logic [N*IDX_WIDTH-1:0]    Out_idx
);

  logic [N-1:0][PM_WIDTH-1:0]  pm_q  [STAGES];
  logic [N-1:0][IDX_WIDTH-1:0] idx_q [STAGES];
  logic [N-1:0][PM_WIDTH-1:0]  pm_cx [STAGES];
  logic [N-1:0][IDX_WIDTH-1:0] idx_cx[STAGES];
  logic [STAGES-1:0]           vld_pipe;
  logic                        adv;

  assign adv       = ~Out_valid | Out_ready;
  assign In_ready  = adv;
  assign Out_valid = vld_pipe[STAGES-1];
  assign Out_pm    = pm_q[STAGES-1];
  assign Out_idx   = idx_q[STAGES-1];

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    logic [N-1:0][PM_WIDTH-1:0]  pm_in;
    logic [N-1:0][IDX_WIDTH-1:0] idx_in;

    if (s == 0) begin : g_src
      for (genvar i = 0; i < N; i++) begin : g_tag
        assign pm_in[i]  = In_pm[i*PM_WIDTH +: PM_WIDTH];
        assign idx_in[i] = IDX_WIDTH'(i);
      end
    end else begin : g_src
      assign pm_in  = pm_q[s-1];
      assign idx_in = idx_q[s-1];
    end

    // Each lane pairs with exactly one partner; the lower position owns the comparator.
    for (genvar i = 0; i < N; i++) begin : g_lane
      if (partner(s, i) > i) begin : g_cas
        cas_tag #(.PM_WIDTH(PM_WIDTH), .IDX_WIDTH(IDX_WIDTH)) u_cas (
          .a_pm  (pm_in[i]),
          .a_idx (idx_in[i]),
          .b_pm  (pm_in[partner(s, i)]),
          .b_idx (idx_in[partner(s, i)]),
          .desc  (dir(s, i)),
          .lo_pm (pm_cx[s][i]),
          .lo_idx(idx_cx[s][i]),
          .hi_pm (pm_cx[s][partner(s, i)]),
          .hi_idx(idx_cx[s][partner(s, i)])
        );
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int s = 0; s < STAGES; s++) begin
        pm_q[s]  <= '0;
        idx_q[s] <= '0;
      end
    end else begin
      if (Flush)
        vld_pipe <= '0;
      else if (adv)
        vld_pipe <= (vld_pipe << 1) | STAGES'(In_valid);
      // Data of flushed/bubble slots is don't-care; only the valid chain gates output.
      if (adv)
        for (int s = 0; s < STAGES; s++) begin
          pm_q[s]  <= pm_cx[s];
          idx_q[s] <= idx_cx[s];
        end
    end
  end

endmodule

// File: tb/tb_pm_sorter_pipe.sv
// Self-checking bench for pm_sorter_pipe (LOG_N=3, PM_WIDTH=8): vector table,
// random scoreboard against a stable selection-sort model, and handshake corners.
module tb_pm_sorter_pipe;
  import pm_sorter_pkg::*;

  localparam int STG = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Flush = 1'b0;
  logic        In_valid = 1'b0;
  logic        In_ready;
  logic [63:0] In_pm = '0;
  logic        Out_valid;
  logic        Out_ready = 1'b1;
  logic [63:0] Out_pm;
  logic [23:0] Out_idx;

  pm_sorter_pipe #(.PM_WIDTH(8), .LOG_N(3)) dut (
    .clk(clk), .rst_n(rst_n), .Flush(Flush), .In_valid(In_valid), .In_ready(In_ready),
    .In_pm(In_pm), .Out_valid(Out_valid), .Out_ready(Out_ready), .Out_pm(Out_pm),
    .Out_idx(Out_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int n_out  = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [63:0] pm;
    logic [63:0] epm;
    logic [23:0] eidx;
    bit          exact;
  } vec_t;
  vec_t tab[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [63:0] pk8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    int v[8];
    logic [63:0] r;
    v = '{a0, a1, a2, a3, a4, a5, a6, a7};
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(v[i]);
    return r;
  endfunction

  function automatic logic [23:0] pk3(input int a0, a1, a2, a3, a4, a5, a6, a7);
    int v[8];
    logic [23:0] r;
    v = '{a0, a1, a2, a3, a4, a5, a6, a7};
    for (int i = 0; i < 8; i++) r[i*3 +: 3] = 3'(v[i]);
    return r;
  endfunction

  // Stable selection sort: repeatedly take the first smallest unused element.
  task automatic ref_sort(input logic [63:0] in, output logic [63:0] epm, output logic [23:0] eidx);
    elem_t e[8];
    bit    used[8];
    int    best;
    for (int i = 0; i < 8; i++) begin
      e[i].pm  = in[i*8 +: 8];
      e[i].idx = 3'(i);
      used[i]  = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      best = -1;
      for (int i = 0; i < 8; i++)
        if (!used[i] && (best < 0 || e[i].pm < e[best].pm)) best = i;
      used[best] = 1'b1;
      epm[k*8 +: 8]  = e[best].pm;
      eidx[k*3 +: 3] = e[best].idx;
    end
  endtask

  function automatic bit perm_ok(input logic [63:0] in, input logic [63:0] opm, input logic [23:0] oidx);
    bit seen[8];
    bit ok;
    int j;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) seen[i] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      j = int'(oidx[k*3 +: 3]);
      if (seen[j]) ok = 1'b0;
      seen[j] = 1'b1;
      if (in[j*8 +: 8] != opm[k*8 +: 8]) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic check_vec(input string nm, input logic [63:0] in, input logic [63:0] opm, input logic [23:0] oidx);
    logic [63:0] epm;
    logic [23:0] eidx;
    ref_sort(in, epm, eidx);
    chk({nm, "_pm"}, opm, epm);
`ifdef PM_SORTER_TIEBREAK_EN
    chk({nm, "_idx"}, 64'(oidx), 64'(eidx));
`else
    chk({nm, "_perm"}, 64'(perm_ok(in, opm, oidx)), 64'd1);
`endif
  endtask

  function automatic logic [63:0] rnd_vec(input int maxv);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'($urandom_range(0, maxv));
    return r;
  endfunction

  // Scoreboard: sampled mid-cycle, mirrors what the next rising edge will transfer.
  logic        hold_v = 1'b0;
  logic [63:0] hold_pm;
  logic [23:0] hold_idx;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_pm", Out_pm, hold_pm);
        chk("hold_idx", 64'(Out_idx), 64'(hold_idx));
      end
      hold_v   = Out_valid && !Out_ready;
      hold_pm  = Out_pm;
      hold_idx = Out_idx;
      if (Out_valid && Out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 64'd1, 64'd0);
        else begin
          check_vec("sb", exp_q.pop_front(), Out_pm, Out_idx);
          n_out++;
        end
      end
      if (Flush) exp_q.delete();
      else if (In_valid && In_ready) exp_q.push_back(In_pm);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t t, input string nm);
    int lat;
    In_pm    = t.pm;
    In_valid = 1'b1;
    step();
    In_valid = 1'b0;
    lat = 0;
    while (!Out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat + 1), 64'(STG));
    chk({nm, "_pm"}, Out_pm, t.epm);
`ifdef PM_SORTER_TIEBREAK_EN
    chk({nm, "_idx"}, 64'(Out_idx), 64'(t.eidx));
`else
    if (t.exact) chk({nm, "_idx"}, 64'(Out_idx), 64'(t.eidx));
    else chk({nm, "_perm"}, 64'(perm_ok(t.pm, Out_pm, Out_idx)), 64'd1);
`endif
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int base, lat, run, acc_n;

    tab[0] = '{pk8(7,3,9,1,0,255,4,2), pk8(0,1,2,3,4,7,9,255), pk3(4,3,7,1,6,0,2,5), 1'b1};
    tab[1] = '{pk8(7,6,5,4,3,2,1,0), pk8(0,1,2,3,4,5,6,7), pk3(7,6,5,4,3,2,1,0), 1'b1};
    tab[2] = '{pk8(5,5,5,5,5,5,5,5), pk8(5,5,5,5,5,5,5,5), pk3(0,1,2,3,4,5,6,7), 1'b0};
    tab[3] = '{pk8(255,0,255,0,128,127,1,254), pk8(0,0,1,127,128,254,255,255),
               pk3(1,3,6,5,4,7,0,2), 1'b0};
    tab[4] = '{pk8(10,20,30,40,50,60,70,80), pk8(10,20,30,40,50,60,70,80),
               pk3(0,1,2,3,4,5,6,7), 1'b1};

    // Reset state
    #23;
    chk("rst_out_valid", 64'(Out_valid), 64'd0);
    chk("rst_out_pm", Out_pm, 64'd0);
    chk("rst_out_idx", 64'(Out_idx), 64'd0);
    chk("rst_in_ready", 64'(In_ready), 64'd1);
    step();
    rst_n = 1'b1;
    step();

    // Reset mid-sort: in-flight vectors must vanish
    base = n_out;
    for (int k = 0; k < 3; k++) begin
      In_valid = 1'b1;
      In_pm    = rnd_vec(255);
      step();
    end
    In_valid = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(Out_valid), 64'd0);
    chk("midrst_out_pm", Out_pm, 64'd0);
    chk("midrst_out_idx", 64'(Out_idx), 64'd0);
    chk("midrst_in_ready", 64'(In_ready), 64'd1);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) step();
    chk("midrst_no_leak", 64'(n_out), 64'(base));

    // Table vectors, one beat each
    for (int k = 0; k < 5; k++) run_vec(tab[k], $sformatf("tab%0d", k));

    // Six back-to-back random vectors (some with heavy ties)
    base = n_out;
    for (int k = 0; k < 6; k++) begin
      In_valid = 1'b1;
      In_pm    = rnd_vec((k % 2 == 0) ? 255 : 3);
      step();
    end
    In_valid = 1'b0;
    lat = 0;
    while (!Out_valid && lat < 20) begin
      step();
      lat++;
    end
    run = 0;
    while (Out_valid && run < 20) begin
      run++;
      step();
    end
    chk("burst_run", 64'(run), 64'd6);
    chk("burst_count", 64'(n_out - base), 64'd6);

    // Back-pressure: fill the pipe, stall three cycles, release
    base     = n_out;
    Out_ready = 1'b0;
    acc_n    = 0;
    In_valid = 1'b1;
    In_pm    = rnd_vec(255);
    for (int c = 0; c < 20 && In_ready; c++) begin
      step();
      acc_n++;
      In_pm = rnd_vec(255);
    end
    chk("bp_fill", 64'(acc_n), 64'(STG));
    for (int c = 0; c < 3; c++) begin
      chk("bp_in_ready", 64'(In_ready), 64'd0);
      chk("bp_out_valid", 64'(Out_valid), 64'd1);
      step();
    end
    Out_ready = 1'b1;
    step();
    In_valid = 1'b0;
    for (int c = 0; c < 30 && n_out < base + STG + 1; c++) step();
    chk("bp_count", 64'(n_out - base), 64'(STG + 1));
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Flush with four vectors in flight and a simultaneous input
    base = n_out;
    for (int k = 0; k < 4; k++) begin
      In_valid = 1'b1;
      In_pm    = rnd_vec(255);
      step();
    end
    Flush = 1'b1;
    In_pm = rnd_vec(255);
    chk("flush_in_ready", 64'(In_ready), 64'd1);
    step();
    Flush    = 1'b0;
    In_valid = 1'b0;
    for (int c = 0; c < STG; c++) begin
      chk("flush_no_out", 64'(Out_valid), 64'd0);
      step();
    end
    chk("flush_dropped", 64'(n_out), 64'(base));
    run_vec(tab[0], "post_flush");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
